// File: rtl/restoring_divider.sv
// Sequential restoring divider: dividend loads into B, quotient lands in B, remainder in A.
// Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands (adds one FIX state).
module restoring_divider #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA_LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int unsigned AW = WIDTH + 1;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
    logic neg_b;
    logic neg_d;
`else
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

    state_t           state;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    a_sh;
    logic [AW-1:0]    t;

    // Shift {A,B} left one place and trial-subtract the divisor.
    always_comb begin
        a_sh = AW'({a, b[WIDTH-1]});
        t    = a_sh - {1'b0, s};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            s       <= '0;
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            neg_b   <= 1'b0;
            neg_d   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ClearA_LoadB) begin
                        a <= '0;
                        b <= Din;
                    end else if (Execute) begin
                        s   <= Din;
                        cnt <= '0;
                        if (Din == '0) begin
                            b       <= '1;
                            DivZero <= 1'b1;
                            Done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            Busy  <= 1'b1;
                            state <= ITER;
`ifdef RESTORING_DIVIDER_SIGNED_EN
                            // Divide magnitudes; signs are reapplied in FIX.
                            neg_b <= b[WIDTH-1];
                            neg_d <= Din[WIDTH-1];
                            b     <= b[WIDTH-1] ? -b : b;
                            s     <= Din[WIDTH-1] ? -Din : Din;
`endif
                        end
                    end
                end
                ITER: begin
                    a   <= t[WIDTH] ? a_sh : t;
                    b   <= {b[WIDTH-2:0], ~t[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
                        state <= FIX;
`else
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
`endif
                    end
                end
`ifdef RESTORING_DIVIDER_SIGNED_EN
                FIX: begin
                    // Truncating division: remainder follows the dividend's sign.
                    b     <= (neg_b ^ neg_d) ? -b : b;
                    a     <= neg_b ? -a : a;
                    state <= DONE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
`endif
                DONE: begin
                    if (!Execute) begin
                        state   <= IDLE;
                        Done    <= 1'b0;
                        DivZero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Aval = a[WIDTH-1:0];
    assign Bval = b;

endmodule

// File: doc/restoring_divider.md
Name: restoring_divider

Overview:
- Sequential 8-bit restoring divider. It uses the same Din/ClearA_LoadB/Execute operator interface as the lab 5 shift-add multiplier and is its inverse datapath.
- Dividend loads into B. Divisor is sampled from Din on Execute.
- One quotient bit is produced per clock. The quotient lands in B and the remainder in A, shown on the same Aval/Bval displays.
- Sits behind the switch/button debouncers in the lab top level, in place of or beside the multiplier.

Parameters:
- WIDTH, 8, operand/quotient/remainder width.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset  input  1  synchronous, active-high reset
- ClearA_LoadB  input  1  level; in IDLE, clears A and loads B with Din (dividend)
- Execute  input  1  level; in IDLE, samples Din as divisor and starts the divide
- Din  input  WIDTH  operand switches
- Aval  output  WIDTH  A register (remainder once done)
- Bval  output  WIDTH  B register (quotient once done)
- Busy  output  1  high in any state other than IDLE and DONE
- Done  output  1  high in DONE
- DivZero  output  1  high in DONE when the divisor was 0; cleared on leaving DONE

Behaviour:
- Single clock. Reset is synchronous and active-high.
- On Reset:
  - state=IDLE
  - A=0, B=0, S=0, cnt=0
  - Busy=0, Done=0, DivZero=0
  - Reset wins over all other inputs, including mid-divide.
- Internal registers: S (divisor), A (WIDTH+1 bits internally; Aval = A[WIDTH-1:0]), B.
- IDLE:
  - ClearA_LoadB=1: A<=0, B<=Din, stay in IDLE. ClearA_LoadB has priority over Execute in the same cycle.
  - Else Execute=1: S<=Din, cnt<=0.
    - Din==0: B<=all ones, A unchanged (0 after load), DivZero<=1, go to DONE.
    - Otherwise go to ITER.
- ITER, once per clock:
  - {A,B} shifted left 1 gives A', B'.
  - T = A' - {0,S}, computed WIDTH+1 bits wide.
  - T[WIDTH]==0: A<=T, B<={B'[WIDTH-1:1],1}.
  - Otherwise: A<=A', B<={B'[WIDTH-1:1],0}.
  - cnt<=cnt+1. When cnt==WIDTH-1, go to DONE (unsigned build) or FIX (signed build).
  - ClearA_LoadB and Execute are ignored while in ITER.
- DONE:
  - Done=1. Outputs are held.
  - Leaves to IDLE only when Execute==0. Holding Execute high never restarts the divide.
  - DivZero clears when leaving to IDLE.
- Latency:
  - Done rises 9 cycles after the edge that samples Execute=1 in IDLE (unsigned build).
  - For a zero divisor, Done rises after 1 cycle.
- Invariant after a completed divide with S≠0: dividend = Bval*S + Aval, and Aval < S.
- Din changing during ITER or DONE has no effect.

Optional Feature:
- Macro: RESTORING_DIVIDER_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On leaving IDLE, the sign of the dividend (B) and of Din are stored, and both operands are replaced by their magnitudes.
  - After ITER, one FIX state runs:
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign (truncating division).
  - Done latency becomes 10 cycles.
  - -128 / -1 yields Bval=0x80, Aval=0x00, with no flag.
  - Divide by zero gives the same result as the unsigned build.
- Undefined: unsigned only; no FIX state.

Test Plan:
- Reset; ClearA_LoadB with Din=0xC5; Execute with Din=0x07, held -> Done at cycle 9; Aval=0x01, Bval=0x1C, DivZero=0.
- Dividend 0x05, divisor 0x07 -> Aval=0x05, Bval=0x00. Dividend 0xFF, divisor 0x01 -> Aval=0x00, Bval=0xFF.
- Dividend 0x42, divisor 0x00 -> Done after 1 cycle; DivZero=1, Bval=0xFF, Aval=0x00. Drop Execute -> IDLE, DivZero=0.
- Execute held high 20 cycles after Done -> Bval/Aval stable, no restart. Execute low 1 cycle then high with Din=0x03 -> new divide runs using the current B as dividend.
- Assert Reset at ITER cycle 4 -> next edge: Aval=Bval=0, Busy=0, Done=0. ClearA_LoadB pulsed during ITER -> ignored.
- Signed build: dividend 0xC5 (-59), divisor 0x07 -> Done at cycle 10; Bval=0xF8 (-8), Aval=0xFD (-3). Dividend 0x80, divisor 0xFF -> Bval=0x80, Aval=0x00.
